// File: rtl/tsv_repair_ctrl_if.sv
// Bundle-side signals of the TSV test/repair sequencer: coder handshake,
// test-pattern drive/sample, and fault-flag results toward the FNS adders.
interface tsv_repair_ctrl_if #(
    parameter int N_TSV = 9
);
    logic             start_scan;
    logic             hold_req;
    logic             hold_ack;
    logic             test_mode;
    logic [N_TSV-1:0] tsv_drive;
    logic [N_TSV-1:0] tsv_rx;
    logic [N_TSV-1:0] f_flag;
    logic [3:0]       fault_cnt;
    logic             cfg_valid;
    logic             done;
    logic             repair_fail;
    logic             busy;

    modport master (
        input  start_scan,
        input  hold_ack,
        input  tsv_rx,
        output hold_req,
        output test_mode,
        output tsv_drive,
        output f_flag,
        output fault_cnt,
        output cfg_valid,
        output done,
        output repair_fail,
        output busy
    );

    modport slave (
        output start_scan,
        output hold_ack,
        output tsv_rx,
        input  hold_req,
        input  test_mode,
        input  tsv_drive,
        input  f_flag,
        input  fault_cnt,
        input  cfg_valid,
        input  done,
        input  repair_fail,
        input  busy
    );
endinterface

// File: rtl/tsv_repair_ctrl.sv
// Run-time test/repair sequencer for the 9-TSV link: pauses the coder, drives
// stuck-at and walking-one patterns, and commits a new fault-flag vector.
module tsv_repair_ctrl #(
    parameter int N_TSV     = 9,
    parameter int MAX_FAULT = 5,
    parameter int SETTLE    = 2,
    parameter int STICKY    = 1
) (
    input  logic              clock,
    input  logic              rst_n,
    tsv_repair_ctrl_if.master bus
);

    localparam int KW = (N_TSV > 1) ? $clog2(N_TSV) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [KW-1:0] K_LAST      = KW'(N_TSV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_ZERO,
        S_ONE,
        S_WALK,
        S_COMMIT,
        S_FAIL
    } state_t;

    state_t state_q, state_d;

    logic [SW-1:0]    settle_q, settle_d;
    logic [KW-1:0]    k_q, k_d;
    logic [N_TSV-1:0] scan_fault_q, scan_fault_d;
    logic [N_TSV-1:0] f_flag_q, f_flag_d;
    logic [3:0]       fault_cnt_q, fault_cnt_d;
    logic             cfg_valid_q, cfg_valid_d;
    logic             done_q, done_d;
    logic             repair_fail_q, repair_fail_d;

    logic             hold_req;
    logic             test_mode;
    logic             busy;
    logic [N_TSV-1:0] tsv_drive;

    logic             settle_last;
    logic [N_TSV-1:0] onehot_k;
    logic [N_TSV-1:0] new_flags;
    int               new_cnt;
    logic             repairable;

    function automatic int popcount(input logic [N_TSV-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < N_TSV; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    assign settle_last = (settle_q == SETTLE_LAST);
    assign onehot_k    = N_TSV'(1) << k_q;
    assign new_flags   = (STICKY != 0) ? (f_flag_q | scan_fault_q) : scan_fault_q;
    assign new_cnt     = popcount(new_flags);
    assign repairable  = (new_cnt <= MAX_FAULT);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start_scan is only looked at in IDLE, so pulses while busy are dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.start_scan) state_d = S_HOLD;
            S_HOLD:   if (bus.hold_ack) state_d = S_ZERO;
            S_ZERO:   if (settle_last) state_d = S_ONE;
            S_ONE:    if (settle_last) state_d = S_WALK;
            S_WALK:   if (settle_last && (k_q == K_LAST)) state_d = S_COMMIT;
            S_COMMIT: state_d = repairable ? S_IDLE : S_FAIL;
            S_FAIL:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        hold_req  = (state_q != S_IDLE);
        test_mode = 1'b0;
        tsv_drive = '0;
        unique case (state_q)
            S_ZERO:   test_mode = 1'b1;
            S_ONE: begin
                test_mode = 1'b1;
                tsv_drive = '1;
            end
            S_WALK: begin
                test_mode = 1'b1;
                tsv_drive = onehot_k;
            end
            S_COMMIT: test_mode = 1'b1;
            S_FAIL:   test_mode = 1'b1;
            default: begin
                test_mode = 1'b0;
                tsv_drive = '0;
            end
        endcase
    end

    // done/cfg_valid are registered so that, in the cycle they pulse,
    // f_flag, fault_cnt and repair_fail already show the outcome.
    always_comb begin
        settle_d      = '0;
        k_d           = '0;
        scan_fault_d  = scan_fault_q;
        f_flag_d      = f_flag_q;
        fault_cnt_d   = fault_cnt_q;
        cfg_valid_d   = 1'b0;
        done_d        = 1'b0;
        repair_fail_d = repair_fail_q;

        if ((state_q == S_ZERO) || (state_q == S_ONE) || (state_q == S_WALK)) begin
            settle_d = settle_last ? '0 : (settle_q + SW'(1));
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_scan) scan_fault_d = '0;
            end
            S_ZERO: begin
                if (settle_last) scan_fault_d = scan_fault_q | bus.tsv_rx;
            end
            S_ONE: begin
                if (settle_last) scan_fault_d = scan_fault_q | ~bus.tsv_rx;
            end
            S_WALK: begin
                k_d = k_q;
                if (settle_last) begin
                    scan_fault_d = scan_fault_q | (bus.tsv_rx ^ onehot_k);
                    k_d          = (k_q == K_LAST) ? '0 : (k_q + KW'(1));
                end
            end
            S_COMMIT: begin
                done_d = 1'b1;
                if (repairable) begin
                    f_flag_d      = new_flags;
                    fault_cnt_d   = 4'(new_cnt);
                    cfg_valid_d   = 1'b1;
                    repair_fail_d = 1'b0;
                end else begin
                    repair_fail_d = 1'b1;
                end
            end
            default: begin
                scan_fault_d = scan_fault_q;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            settle_q      <= '0;
            k_q           <= '0;
            scan_fault_q  <= '0;
            f_flag_q      <= '0;
            fault_cnt_q   <= '0;
            cfg_valid_q   <= 1'b0;
            done_q        <= 1'b0;
            repair_fail_q <= 1'b0;
        end else begin
            settle_q      <= settle_d;
            k_q           <= k_d;
            scan_fault_q  <= scan_fault_d;
            f_flag_q      <= f_flag_d;
            fault_cnt_q   <= fault_cnt_d;
            cfg_valid_q   <= cfg_valid_d;
            done_q        <= done_d;
            repair_fail_q <= repair_fail_d;
        end
    end

    assign bus.hold_req    = hold_req;
    assign bus.test_mode   = test_mode;
    assign bus.tsv_drive   = tsv_drive;
    assign bus.busy        = busy;
    assign bus.f_flag      = f_flag_q;
    assign bus.fault_cnt   = fault_cnt_q;
    assign bus.cfg_valid   = cfg_valid_q;
    assign bus.done        = done_q;
    assign bus.repair_fail = repair_fail_q;

endmodule

// File: tb/tb_tsv_repair_ctrl.sv
// Self-checking bench for tsv_repair_ctrl: a faulty-channel loopback and a
// pattern-set reference model predict the flags committed by each scan.
module tb_tsv_repair_ctrl;

    localparam int N    = 9;
    localparam int MAXF = 5;

    logic clock = 1'b0;
    logic rst_n = 1'b1;

    always #5 clock = ~clock;

    tsv_repair_ctrl_if #(.N_TSV(N)) bus ();

    tsv_repair_ctrl #(
        .N_TSV    (N),
        .MAX_FAULT(MAXF),
        .SETTLE   (2),
        .STICKY   (1)
    ) dut (
        .clock(clock),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [N-1:0] s0Mask;
    logic [N-1:0] s1Mask;
    int           bridgeA;
    int           bridgeB;

    logic [N-1:0] modelFlags;
    bit           modelFail;

    int total = 0;
    int bad   = 0;

    // Faulty TSV bundle: optional wired-OR bridge, then stuck-at-0/1 masks.
    function automatic logic [N-1:0] channel(input logic [N-1:0] d, input logic [N-1:0] s0,
                                             input logic [N-1:0] s1, input int a, input int b);
        logic [N-1:0] r;
        r = d;
        if (a >= 0 && b >= 0) begin
            r[a] = d[a] | d[b];
            r[b] = d[a] | d[b];
        end
        return (r & ~s0) | s1;
    endfunction

    assign bus.tsv_rx = channel(bus.tsv_drive, s0Mask, s1Mask, bridgeA, bridgeB);

    // Pattern i of a scan: all-0, all-1, then one-hot walk over every TSV.
    function automatic logic [N-1:0] patternFor(input int i);
        logic [N-1:0] p;
        if (i == 0) p = '0;
        else if (i == 1) p = '1;
        else p = N'(1) << (i - 2);
        return p;
    endfunction

    // A TSV is faulty if any pattern comes back different from what was sent.
    function automatic logic [N-1:0] expectedScan();
        logic [N-1:0] acc;
        acc = '0;
        for (int i = 0; i < N + 2; i++) begin
            acc |= channel(patternFor(i), s0Mask, s1Mask, bridgeA, bridgeB) ^ patternFor(i);
        end
        return acc;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setFaults(input logic [N-1:0] s0, input logic [N-1:0] s1,
                             input int a, input int b);
        s0Mask  = s0;
        s1Mask  = s1;
        bridgeA = a;
        bridgeB = b;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 0);
        checkOutput({tag, "_hold_req"}, 32'(bus.hold_req), 0);
        checkOutput({tag, "_test_mode"}, 32'(bus.test_mode), 0);
        checkOutput({tag, "_tsv_drive"}, 32'(bus.tsv_drive), 0);
        checkOutput({tag, "_f_flag"}, 32'(bus.f_flag), 0);
        checkOutput({tag, "_fault_cnt"}, 32'(bus.fault_cnt), 0);
        checkOutput({tag, "_cfg_valid"}, 32'(bus.cfg_valid), 0);
        checkOutput({tag, "_done"}, 32'(bus.done), 0);
        checkOutput({tag, "_repair_fail"}, 32'(bus.repair_fail), 0);
    endtask

    task automatic pulseReset();
        @(negedge clock);
        rst_n = 1'b0;
        #1;
        modelFlags = '0;
        modelFail  = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    // One complete scan; returns at the negedge after the done pulse.
    task automatic applyStimulus(input int ackDelay, input bit pokeInWalk);
        logic [N-1:0] newFlags;
        bit           pass;
        int           c;
        newFlags = modelFlags | expectedScan();
        pass     = ($countones(newFlags) <= MAXF);

        @(negedge clock);
        bus.start_scan = 1'b1;
        @(negedge clock);
        bus.start_scan = 1'b0;
        checkOutput("hold_req_up", 32'(bus.hold_req), 1);
        checkOutput("busy_up", 32'(bus.busy), 1);
        for (int i = 0; i < ackDelay; i++) begin
            checkOutput("test_mode_hold", 32'(bus.test_mode), 0);
            @(negedge clock);
        end
        bus.hold_ack = 1'b1;
        @(negedge clock);
        bus.hold_ack = 1'b0;
        checkOutput("test_mode_up", 32'(bus.test_mode), 1);

        c = 0;
        while (!bus.done && c < 40) begin
            if (c < 22) checkOutput("tsv_drive", 32'(bus.tsv_drive), 32'(patternFor(c / 2)));
            bus.start_scan = pokeInWalk && (c == 10);
            @(negedge clock);
            c++;
        end
        bus.start_scan = 1'b0;
        checkOutput("done_latency", 32'(c), 23);
        checkOutput("cfg_valid", 32'(bus.cfg_valid), 32'(pass));
        checkOutput("repair_fail", 32'(bus.repair_fail), 32'(!pass));
        if (pass) modelFlags = newFlags;
        modelFail = !pass;
        checkOutput("f_flag", 32'(bus.f_flag), 32'(modelFlags));
        checkOutput("fault_cnt", 32'(bus.fault_cnt), 32'($countones(modelFlags)));

        @(negedge clock);
        checkOutput("done_pulse", 32'(bus.done), 0);
        checkOutput("cfg_valid_pulse", 32'(bus.cfg_valid), 0);
        checkOutput("hold_req_down", 32'(bus.hold_req), 0);
        checkOutput("test_mode_down", 32'(bus.test_mode), 0);
        repeat (4) @(negedge clock);
        checkOutput("busy_idle", 32'(bus.busy), 0);
    endtask

    task automatic resetMidWalk();
        @(negedge clock);
        bus.start_scan = 1'b1;
        @(negedge clock);
        bus.start_scan = 1'b0;
        bus.hold_ack   = 1'b1;
        @(negedge clock);
        bus.hold_ack = 1'b0;
        for (int c = 0; c < 12; c++) @(negedge clock);
        checkOutput("walk_k4_drive", 32'(bus.tsv_drive), 32'h010);
        rst_n = 1'b0;
        #1;
        modelFlags = '0;
        modelFail  = 1'b0;
        checkAllZero("midwalk_rst");
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.start_scan = 1'b0;
        bus.hold_ack   = 1'b0;
        setFaults('0, '0, -1, -1);
        modelFlags = '0;
        modelFail  = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        checkAllZero("reset");
        @(negedge clock);
        rst_n = 1'b1;

        $display("[TB] TSV3 stuck-at-0, TSV7 stuck-at-1");
        setFaults(9'b000001000, 9'b010000000, -1, -1);
        applyStimulus(2, 1'b0);
        checkOutput("sa_flags", 32'(bus.f_flag), 32'h088);
        checkOutput("sa_cnt", 32'(bus.fault_cnt), 2);

        $display("[TB] reset during walk");
        resetMidWalk();
        checkOutput("post_rst_flags", 32'(bus.f_flag), 0);

        $display("[TB] fault-free loopback");
        setFaults('0, '0, -1, -1);
        applyStimulus(3, 1'b0);
        checkOutput("clean_flags", 32'(bus.f_flag), 0);

        $display("[TB] sticky accumulation");
        setFaults('0, 9'b000000001, -1, -1);
        applyStimulus(1, 1'b0);
        setFaults('0, '0, 8, 7);
        applyStimulus(0, 1'b0);
        checkOutput("sticky_flags", 32'(bus.f_flag), 32'h181);
        checkOutput("sticky_cnt", 32'(bus.fault_cnt), 3);

        $display("[TB] six faults -> repair fails");
        setFaults('0, 9'b101110101, -1, -1);
        applyStimulus(2, 1'b0);
        checkOutput("fail_flags_kept", 32'(bus.f_flag), 32'h181);
        checkOutput("fail_sticky", 32'(bus.repair_fail), 1);

        $display("[TB] start_scan poked during walk");
        setFaults('0, '0, -1, -1);
        applyStimulus(1, 1'b1);

        $display("[TB] randomized scans");
        for (int it = 0; it < 8; it++) begin
            logic [N-1:0] r0;
            logic [N-1:0] r1;
            int           a;
            int           b;
            if (it % 3 == 0) pulseReset();
            r0 = N'($urandom) & N'($urandom) & N'($urandom);
            r1 = N'($urandom) & N'($urandom) & N'($urandom);
            a  = -1;
            b  = -1;
            if ($urandom_range(1, 0) == 1) begin
                a = $urandom_range(N - 2, 0);
                b = a + 1;
            end
            setFaults(r0, r1, a, b);
            applyStimulus($urandom_range(4, 0), 1'($urandom_range(1, 0)));
        end

        $display("[TB] hold_ack never returned");
        setFaults('0, '0, -1, -1);
        @(negedge clock);
        bus.start_scan = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (i % 10 == 9) begin
                checkOutput("stall_busy", 32'(bus.busy), 1);
                checkOutput("stall_hold_req", 32'(bus.hold_req), 1);
                checkOutput("stall_test_mode", 32'(bus.test_mode), 0);
                checkOutput("stall_drive", 32'(bus.tsv_drive), 0);
            end
        end
        bus.start_scan = 1'b0;
        pulseReset();
        #1;
        checkAllZero("final_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
